seq_stage_ctrl: RTL and testbench
=================================

Name: seq_stage_ctrl

Overview:
Multi-cycle sequencer for the Y86-64 SEQ datapath. Steps each instruction through Fetch, Decode, Execute, Memory, Writeback and PC-update, one stage at a time, and drives the per-stage enables for fetch, register file, ALU/CC, data memory and PC. Handles memory wait-states, timeouts, halt and exceptions, and reports processor status (Y86 stat codes).

Parameters:
MEM_TIMEOUT, 16, max wait cycles for imem/dmem ack before ADR fault; 0 disables timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
icode  input  4  instruction code from fetch logic, valid in the imem_ack cycle
cnd  input  1  condition result from execute logic, valid during EXECUTE
imem_ack  input  1  instruction memory transfer done
imem_err  input  1  instruction address invalid, qualified by imem_ack
dmem_ack  input  1  data memory transfer done
dmem_err  input  1  data address invalid, qualified by dmem_ack
imem_req  output  1  fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (qualifies dmem_req)
dec_en  output  1  register-file read / decode enable
exe_en  output  1  ALU enable
cc_we  output  1  condition-code register write
rf_we_e  output  1  register write of valE (dstE)
rf_we_m  output  1  register write of valM (dstM)
pc_we  output  1  PC register load
stage  output  3  current state encoding
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
halted  output  1  high in HALT state
instr_count  output  CNT_W  retired instructions

Behaviour:
- States/encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, PCUPD=5, HALT=6. Registered state; all outputs except stat/instr_count decoded combinationally from state plus internal registers icode_q, cnd_q.
- Reset (rst_n low at clk edge): state=FETCH, stat=1, icode_q=0, cnd_q=0, instr_count=0, wait counter=0. Reset overrides any state, incl. mid-handshake; pending requests drop in the cycle after reset is sampled.
- FETCH: imem_req=1. On imem_ack: icode_q<=icode; imem_err=1 -> HALT, stat<=3; else -> DECODE. No ack -> stay, wait counter++.
- DECODE: dec_en=1. icode_q=0 -> HALT, stat<=2. icode_q>4'hB -> HALT, stat<=4. Else -> EXECUTE.
- EXECUTE: exe_en=1; cc_we=1 only for icode 6; cnd_q<=cnd. Next: MEMORY for icodes 4,5,8,9,A,B; else WRITEBACK.
- MEMORY: dmem_req=1; dmem_we=1 for icodes 4,8,A. On dmem_ack: dmem_err -> HALT, stat<=3 (no writeback, no pc_we); else -> WRITEBACK. No ack -> stay, wait counter++.
- WRITEBACK: one cycle. rf_we_e=1 for icodes 3,6,8,9,A,B, and for 2 only if cnd_q. rf_we_m=1 for icodes 5,B. icodes 1,4,7 assert neither. -> PCUPD.
- PCUPD: pc_we=1; instr_count++ (saturates at all-ones); -> FETCH.
- HALT: terminal until reset; halted=1; all enables/requests 0; stat holds.
- Wait counter: cleared on every state entry. If MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT in FETCH or MEMORY with no ack -> HALT, stat<=3. Ack on the same cycle the count is reached wins (transfer completes).
- Latency: zero-wait instruction without memory = 5 cycles (F,D,E,W,P); with memory = 6; each wait state adds one cycle.
- Enables are single-cycle pulses per instruction; never more than one of imem_req/dmem_req high.

Test Plan:
- Reset then irmovq (icode 3), imem_ack immediate -> stage 0,1,2,4,5 on successive cycles; rf_we_e pulse in cycle 4, pc_we in 5; instr_count=1; stat=1.
- mrmovq (icode 5), dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, rf_we_m=1 in following WRITEBACK, total 9 cycles.
- cmovxx (icode 2) with cnd=0 then cnd=1 -> rf_we_e 0 then 1; OPq (icode 6) -> cc_we=1 only in EXECUTE.
- halt (icode 0) -> HALT after DECODE, stat=2, halted=1, no pc_we, instr_count unchanged; icode 4'hC -> stat=4.
- pushq with dmem_ack never asserted, MEM_TIMEOUT=16 -> HALT after 16 MEMORY cycles, stat=3; imem_ack with imem_err -> stat=3.
- rst_n low during MEMORY wait -> next cycle stage=0, stat=1, dmem_req=0, instr_count=0.

Source files
------------

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle Y86-64 SEQ sequencer: F, D, E, M, W, P stages with per-stage enables and stat codes.
// Latency: 5 cycles per non-memory instruction, 6 with memory, plus one per memory wait state.
// Backpressure: imem_ack/dmem_ack stall FETCH/MEMORY; a bounded wait ends in an ADR halt.
module seq_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       icode,
  input  logic             cnd,
  input  logic             imem_ack,
  input  logic             imem_err,
  input  logic             dmem_ack,
  input  logic             dmem_err,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             dec_en,
  output logic             exe_en,
  output logic             cc_we,
  output logic             rf_we_e,
  output logic             rf_we_m,
  output logic             pc_we,
  output logic [2:0]       stage,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_PCUPD     = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Counter is one bit wider than needed to hold MEM_TIMEOUT so the increment compare never wraps.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W:0] TIMEOUT_V = MEM_TIMEOUT[WAIT_W:0];

  state_t            state, state_nxt;
  logic [2:0]        stat_nxt;
  logic [3:0]        icode_q;
  logic              cnd_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W:0]   wait_inc;
  logic              timeout_hit;

  // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
  function automatic logic uses_mem(input logic [3:0] ic);
    case (ic)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: uses_mem = 1'b1;
      default:                            uses_mem = 1'b0;
    endcase
  endfunction

  assign wait_inc    = {1'b0, wait_cnt} + 1'b1;
  // The cycle whose miss would make the wait count reach the limit is the last one allowed.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == TIMEOUT_V);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and next-stat selection; an ack in the timeout cycle still completes the transfer.
  always_comb begin
    state_nxt = state;
    stat_nxt  = stat;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          if (imem_err) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end else begin
            state_nxt = S_DECODE;
          end
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end
      end
      S_DECODE: begin
        if (icode_q == 4'h0) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_HLT;
        end else if (icode_q > 4'hB) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_INS;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: state_nxt = uses_mem(icode_q) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (dmem_ack) begin
          if (dmem_err) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPD;
      S_PCUPD:     state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // Per-stage enables decoded from the current state and the latched instruction fields.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    dec_en   = 1'b0;
    exe_en   = 1'b0;
    cc_we    = 1'b0;
    rf_we_e  = 1'b0;
    rf_we_m  = 1'b0;
    pc_we    = 1'b0;
    case (state)
      S_FETCH:   imem_req = 1'b1;
      S_DECODE:  dec_en   = 1'b1;
      S_EXECUTE: begin
        exe_en = 1'b1;
        cc_we  = (icode_q == 4'h6);
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (icode_q == 4'h4) || (icode_q == 4'h8) || (icode_q == 4'hA);
      end
      S_WRITEBACK: begin
        case (icode_q)
          4'h3, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: rf_we_e = 1'b1;
          4'h2:                               rf_we_e = cnd_q;
          default:                            rf_we_e = 1'b0;
        endcase
        rf_we_m = (icode_q == 4'h5) || (icode_q == 4'hB);
      end
      S_PCUPD: pc_we = 1'b1;
      default: ;
    endcase
  end

  assign stage  = state;
  assign halted = (state == S_HALT);

  // Datapath-side bookkeeping: stat, latched icode/cnd, retire counter and memory wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat        <= STAT_AOK;
      icode_q     <= 4'h0;
      cnd_q       <= 1'b0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      stat <= stat_nxt;
      if (state == S_FETCH && imem_ack) icode_q <= icode;
      if (state == S_EXECUTE)           cnd_q   <= cnd;
      if (state == S_PCUPD && instr_count != '1)
        instr_count <= instr_count + 1'b1;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_MEMORY) && wait_cnt != '1)
        wait_cnt <= wait_inc[WAIT_W-1:0];
    end
  end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: stage walk, enables, stalls, timeout, halt/fault and reset.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Memory acks are applied cycle by cycle from the stimulus; nothing waits on the DUT.
module tb_seq_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic        cnd = 1'b0;
  logic        imem_ack = 1'b0, imem_err = 1'b0, dmem_ack = 1'b0, dmem_err = 1'b0;
  logic        imem_req, dmem_req, dmem_we, dec_en, exe_en, cc_we;
  logic        rf_we_e, rf_we_m, pc_we, halted;
  logic [2:0]  stage, stat;
  logic [31:0] instr_count;
  logic [9:0]  en;

  int n_chk = 0;
  int n_err = 0;

  // Enable vector: {imem_req,dmem_req,dmem_we,dec_en,exe_en,cc_we,rf_we_e,rf_we_m,pc_we,halted}
  localparam logic [9:0] EN_F   = 10'h200;
  localparam logic [9:0] EN_MR  = 10'h100;
  localparam logic [9:0] EN_MW  = 10'h180;
  localparam logic [9:0] EN_D   = 10'h040;
  localparam logic [9:0] EN_E   = 10'h020;
  localparam logic [9:0] EN_ECC = 10'h030;
  localparam logic [9:0] EN_WE  = 10'h008;
  localparam logic [9:0] EN_WM  = 10'h004;
  localparam logic [9:0] EN_W0  = 10'h000;
  localparam logic [9:0] EN_P   = 10'h002;
  localparam logic [9:0] EN_H   = 10'h001;

  seq_stage_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .cnd(cnd),
    .imem_ack(imem_ack), .imem_err(imem_err), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .dec_en(dec_en),
    .exe_en(exe_en), .cc_we(cc_we), .rf_we_e(rf_we_e), .rf_we_m(rf_we_m), .pc_we(pc_we),
    .stage(stage), .stat(stat), .halted(halted), .instr_count(instr_count)
  );

  assign en = {imem_req, dmem_req, dmem_we, dec_en, exe_en, cc_we, rf_we_e, rf_we_m, pc_we, halted};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check stage and enables for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [9:0] ee);
    chk({tag, "_stage"}, 32'(stage), 32'(es));
    chk({tag, "_en"}, 32'(en), 32'(ee));
    step();
  endtask

  task automatic fetch(input string tag, input logic [3:0] ic);
    icode = ic;
    imem_ack = 1'b1;
    cyc(tag, 3'd0, EN_F);
    imem_ack = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_err = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0; cnd = 1'b0;
    step();
    rst_n = 1'b1;
    chk({tag, "_rst_stage"}, 32'(stage), 32'd0);
    chk({tag, "_rst_stat"}, 32'(stat), 32'd1);
    chk({tag, "_rst_cnt"}, instr_count, 32'd0);
    chk({tag, "_rst_en"}, 32'(en), 32'(EN_F));
  endtask

  initial begin
    step();
    do_reset("init");

    // irmovq, zero wait
    fetch("irm_f", 4'h3);
    cyc("irm_d", 3'd1, EN_D);
    cyc("irm_e", 3'd2, EN_E);
    cyc("irm_w", 3'd4, EN_WE);
    cyc("irm_p", 3'd5, EN_P);
    chk("irm_cnt", instr_count, 32'd1);
    chk("irm_stat", 32'(stat), 32'd1);

    // mrmovq, dmem_ack after 3 wait cycles
    fetch("mrm_f", 4'h5);
    cyc("mrm_d", 3'd1, EN_D);
    cyc("mrm_e", 3'd2, EN_E);
    for (int i = 0; i < 3; i++) cyc("mrm_mwait", 3'd3, EN_MR);
    dmem_ack = 1'b1;
    cyc("mrm_mack", 3'd3, EN_MR);
    dmem_ack = 1'b0;
    cyc("mrm_w", 3'd4, EN_WM);
    cyc("mrm_p", 3'd5, EN_P);
    chk("mrm_cnt", instr_count, 32'd2);

    // cmovxx not taken, then taken
    fetch("cmov0_f", 4'h2);
    cyc("cmov0_d", 3'd1, EN_D);
    cnd = 1'b0;
    cyc("cmov0_e", 3'd2, EN_E);
    cyc("cmov0_w", 3'd4, EN_W0);
    cyc("cmov0_p", 3'd5, EN_P);
    fetch("cmov1_f", 4'h2);
    cyc("cmov1_d", 3'd1, EN_D);
    cnd = 1'b1;
    cyc("cmov1_e", 3'd2, EN_E);
    cnd = 1'b0;
    cyc("cmov1_w", 3'd4, EN_WE);
    cyc("cmov1_p", 3'd5, EN_P);

    // OPq writes condition codes in EXECUTE only
    fetch("opq_f", 4'h6);
    cyc("opq_d", 3'd1, EN_D);
    cyc("opq_e", 3'd2, EN_ECC);
    cyc("opq_w", 3'd4, EN_WE);
    cyc("opq_p", 3'd5, EN_P);

    // rmmovq: memory write, no register write
    fetch("rmm_f", 4'h4);
    cyc("rmm_d", 3'd1, EN_D);
    cyc("rmm_e", 3'd2, EN_E);
    dmem_ack = 1'b1;
    cyc("rmm_m", 3'd3, EN_MW);
    dmem_ack = 1'b0;
    cyc("rmm_w", 3'd4, EN_W0);
    cyc("rmm_p", 3'd5, EN_P);
    chk("rmm_cnt", instr_count, 32'd6);

    // halt: terminal, stat HLT, counter unchanged, ignores acks
    fetch("hlt_f", 4'h0);
    cyc("hlt_d", 3'd1, EN_D);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) cyc("hlt_h", 3'd6, EN_H);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("hlt_stat", 32'(stat), 32'd2);
    chk("hlt_cnt", instr_count, 32'd6);

    // invalid instruction
    do_reset("ins");
    fetch("ins_f", 4'hC);
    cyc("ins_d", 3'd1, EN_D);
    cyc("ins_h", 3'd6, EN_H);
    chk("ins_stat", 32'(stat), 32'd4);

    // pushq with no dmem ack: 16 MEMORY cycles then ADR halt
    do_reset("tmo");
    fetch("tmo_f", 4'hA);
    cyc("tmo_d", 3'd1, EN_D);
    cyc("tmo_e", 3'd2, EN_E);
    for (int i = 0; i < 16; i++) cyc("tmo_m", 3'd3, EN_MW);
    cyc("tmo_h", 3'd6, EN_H);
    chk("tmo_stat", 32'(stat), 32'd3);
    chk("tmo_cnt", instr_count, 32'd0);

    // ack arriving in the timeout cycle completes the transfer
    do_reset("edge");
    fetch("edge_f", 4'h5);
    cyc("edge_d", 3'd1, EN_D);
    cyc("edge_e", 3'd2, EN_E);
    for (int i = 0; i < 15; i++) cyc("edge_m", 3'd3, EN_MR);
    dmem_ack = 1'b1;
    cyc("edge_mack", 3'd3, EN_MR);
    dmem_ack = 1'b0;
    cyc("edge_w", 3'd4, EN_WM);
    cyc("edge_p", 3'd5, EN_P);
    chk("edge_cnt", instr_count, 32'd1);
    chk("edge_stat", 32'(stat), 32'd1);

    // data fault: halt without writeback or pc update
    fetch("derr_f", 4'h5);
    cyc("derr_d", 3'd1, EN_D);
    cyc("derr_e", 3'd2, EN_E);
    dmem_ack = 1'b1; dmem_err = 1'b1;
    cyc("derr_m", 3'd3, EN_MR);
    dmem_ack = 1'b0; dmem_err = 1'b0;
    cyc("derr_h", 3'd6, EN_H);
    chk("derr_stat", 32'(stat), 32'd3);
    chk("derr_cnt", instr_count, 32'd1);

    // instruction fetch fault
    do_reset("ierr");
    icode = 4'h3; imem_ack = 1'b1; imem_err = 1'b1;
    cyc("ierr_f", 3'd0, EN_F);
    imem_ack = 1'b0; imem_err = 1'b0;
    cyc("ierr_h", 3'd6, EN_H);
    chk("ierr_stat", 32'(stat), 32'd3);

    // reset in the middle of a MEMORY wait
    do_reset("mid");
    fetch("mid0_f", 4'h3);
    cyc("mid0_d", 3'd1, EN_D);
    cyc("mid0_e", 3'd2, EN_E);
    cyc("mid0_w", 3'd4, EN_WE);
    cyc("mid0_p", 3'd5, EN_P);
    fetch("mid_f", 4'h5);
    cyc("mid_d", 3'd1, EN_D);
    cyc("mid_e", 3'd2, EN_E);
    cyc("mid_m0", 3'd3, EN_MR);
    cyc("mid_m1", 3'd3, EN_MR);
    chk("mid_cnt_pre", instr_count, 32'd1);
    do_reset("mid");
    chk("mid_dmem_req", 32'(dmem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
